// File: rtl/nmea_pkg.sv
// Shared types and constants for the $GPZDA sentence parser.
// The optional checksum check is enabled by defining NMEA_ZDA_CHKSUM_EN.
package nmea_pkg;

   // Parser FSM states
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HDR,
      ST_TIME,
      ST_FRAC,
      ST_DAY,
      ST_MONTH,
      ST_YEAR,
      ST_SKIP,
      ST_CHK_HI,
      ST_CHK_LO
   } nmea_state_e;

   // ASCII constants
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_COMMA  = 8'h2C;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_DOT    = 8'h2E;
   localparam logic [7:0] CH_ZERO   = 8'h30;
   localparam logic [7:0] CH_NINE   = 8'h39;
   localparam logic [7:0] CH_UPPER_A = 8'h41;
   localparam logic [7:0] CH_UPPER_F = 8'h46;

   // Header that must follow '$', including the first field separator
   localparam int HDR_LEN = 6;
   localparam logic [0:HDR_LEN-1][7:0] HDR_STR = {8'h47, 8'h50, 8'h5A, 8'h44, 8'h41, 8'h2C};

   // Field digit counts
   localparam int PAIR_DIGITS  = 2;
   localparam int DAY_DIGITS   = 2;
   localparam int MONTH_DIGITS = 2;
   localparam int YEAR_DIGITS  = 4;

   // Accumulator geometry
   localparam int ACC_W = 14;
   localparam int CNT_W = 4;

   // Output field widths
   localparam int HOUR_W  = 5;
   localparam int MIN_W   = 6;
   localparam int SEC_W   = 6;
   localparam int DAY_W   = 5;
   localparam int MONTH_W = 4;
   localparam int YEAR_W  = 12;

   // Uppercase hexadecimal character test
   function automatic logic is_hex(input logic [7:0] b);
      return ((b >= CH_ZERO) && (b <= CH_NINE)) || ((b >= CH_UPPER_A) && (b <= CH_UPPER_F));
   endfunction

   // Value of an uppercase hex character (only meaningful when is_hex is true)
   function automatic logic [3:0] hex_val(input logic [7:0] b);
      logic [7:0] v;
      if (b <= CH_NINE) v = b - CH_ZERO;
      else              v = b - (CH_UPPER_A - 8'd10);
      return v[3:0];
   endfunction

endpackage

// File: rtl/nmea_dec_acc.sv
// Decimal digit accumulator: value = value*10 + digit, plus a digit count.
// Asserting clear together with the digit strobe starts a new number with
// that digit, so back-to-back fields need no idle cycle between them.
module nmea_dec_acc
   import nmea_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             dig_stb_i,
   input  logic [7:0]       ascii_i,
   output logic [ACC_W-1:0] value_o,
   output logic [CNT_W-1:0] count_o,
   output logic             is_digit_o
);

   logic [ACC_W-1:0] val_q, val_d, base_val;
   logic [CNT_W-1:0] cnt_q, cnt_d, base_cnt;

   assign is_digit_o = (ascii_i >= CH_ZERO) && (ascii_i <= CH_NINE);
   assign value_o    = val_q;
   assign count_o    = cnt_q;

   // Next value: optional clear, then x*10 as (x<<3)+(x<<1) plus the low nibble of the ASCII digit
   always_comb begin
      base_val = clr_i ? '0 : val_q;
      base_cnt = clr_i ? '0 : cnt_q;
      val_d    = base_val;
      cnt_d    = base_cnt;
      if (dig_stb_i) begin
         val_d = (base_val << 3) + (base_val << 1) + {{(ACC_W-4){1'b0}}, ascii_i[3:0]};
         if (base_cnt != '1) cnt_d = base_cnt + 1'b1;
      end
   end

   // Accumulator registers
   always_ff @(posedge clk) begin
      if (rst) begin
         val_q <= '0;
         cnt_q <= '0;
      end else begin
         val_q <= val_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/nmea_zda_ctrl.sv
// $GPZDA sentence controller: header match, field split, decimal conversion,
// and publication of a coherent UTC time/date set with a one-cycle strobe.
// Define NMEA_ZDA_CHKSUM_EN to parse and verify the two-digit XOR checksum;
// otherwise the sentence is published on '*'.
// Handshake: a byte is consumed on every rising clk edge where rx_valid_i is
// high; there is no back-pressure, so one byte per cycle is always accepted.
module nmea_zda_ctrl
   import nmea_pkg::*;
#(
   parameter int MAX_FRAC = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         rx_data_i,
   input  logic               rx_valid_i,
   output logic [HOUR_W-1:0]  hour_o,
   output logic [MIN_W-1:0]   minute_o,
   output logic [SEC_W-1:0]   second_o,
   output logic [DAY_W-1:0]   day_o,
   output logic [MONTH_W-1:0] month_o,
   output logic [YEAR_W-1:0]  year_o,
   output logic               time_valid_o,
   output logic               parse_err_o,
   output logic               busy_o,
   output nmea_state_e        state_o
);

   nmea_state_e state_q, state_d;
   logic [2:0]  hdr_idx_q, hdr_idx_d;
   logic [1:0]  pair_q, pair_d;          // which hh/mm/ss pair the TIME field is on

   logic [HOUR_W-1:0]  sh_hour_q, sh_hour_d;
   logic [MIN_W-1:0]   sh_min_q, sh_min_d;
   logic [SEC_W-1:0]   sh_sec_q, sh_sec_d;
   logic [DAY_W-1:0]   sh_day_q, sh_day_d;
   logic [MONTH_W-1:0] sh_mon_q, sh_mon_d;
   logic [YEAR_W-1:0]  sh_year_q, sh_year_d;

   logic time_valid_q, parse_err_q;
   logic publish, err;

   logic             acc_clr, acc_stb, is_digit;
   logic [ACC_W-1:0] acc_val;
   logic [CNT_W-1:0] acc_cnt;
   logic             acc_unused;

`ifdef NMEA_ZDA_CHKSUM_EN
   logic [7:0] chk_q, chk_d;
   logic [3:0] chk_hi_q, chk_hi_d;
`endif

   // Accumulator bits above the widest field are never published
   assign acc_unused = ^acc_val[ACC_W-1:YEAR_W];

   nmea_dec_acc u_acc (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (acc_clr),
      .dig_stb_i  (acc_stb),
      .ascii_i    (rx_data_i),
      .value_o    (acc_val),
      .count_o    (acc_cnt),
      .is_digit_o (is_digit)
   );

   // Next-state, field latching, accumulator control and checksum update
   always_comb begin
      state_d   = state_q;
      hdr_idx_d = hdr_idx_q;
      pair_d    = pair_q;
      sh_hour_d = sh_hour_q;
      sh_min_d  = sh_min_q;
      sh_sec_d  = sh_sec_q;
      sh_day_d  = sh_day_q;
      sh_mon_d  = sh_mon_q;
      sh_year_d = sh_year_q;
      acc_clr   = 1'b0;
      acc_stb   = 1'b0;
      publish   = 1'b0;
      err       = 1'b0;
`ifdef NMEA_ZDA_CHKSUM_EN
      chk_d     = chk_q;
      chk_hi_d  = chk_hi_q;
`endif
      if (rx_valid_i) begin
         if (rx_data_i == CH_DOLLAR) begin
            // '$' always (re)starts a sentence; an interrupted one is dropped silently
            state_d   = ST_HDR;
            hdr_idx_d = '0;
            acc_clr   = 1'b1;
`ifdef NMEA_ZDA_CHKSUM_EN
            chk_d     = '0;
`endif
         end else begin
`ifdef NMEA_ZDA_CHKSUM_EN
            if ((state_q == ST_HDR) || (state_q == ST_TIME) || (state_q == ST_FRAC) ||
                (state_q == ST_DAY) || (state_q == ST_MONTH) || (state_q == ST_YEAR) ||
                (state_q == ST_SKIP)) begin
               if (rx_data_i != CH_STAR) chk_d = chk_q ^ rx_data_i;
            end
`endif
            case (state_q)
               ST_IDLE: ;
               ST_HDR: begin
                  if (rx_data_i == HDR_STR[hdr_idx_q]) begin
                     if (hdr_idx_q == 3'(HDR_LEN-1)) begin
                        state_d = ST_TIME;
                        acc_clr = 1'b1;
                        pair_d  = '0;
                     end else begin
                        hdr_idx_d = hdr_idx_q + 3'd1;
                     end
                  end else begin
                     state_d = ST_IDLE;  // some other sentence type
                  end
               end
               ST_TIME: begin
                  if (is_digit) begin
                     if (acc_cnt == CNT_W'(PAIR_DIGITS)) begin
                        // previous pair complete: latch it and start the next pair with this digit
                        if (pair_q == 2'd2) begin
                           err = 1'b1;
                        end else begin
                           if (pair_q == 2'd0) sh_hour_d = acc_val[HOUR_W-1:0];
                           else                sh_min_d  = acc_val[MIN_W-1:0];
                           pair_d  = pair_q + 2'd1;
                           acc_clr = 1'b1;
                           acc_stb = 1'b1;
                        end
                     end else begin
                        acc_stb = 1'b1;
                     end
                  end else if (((rx_data_i == CH_DOT) || (rx_data_i == CH_COMMA)) &&
                               (pair_q == 2'd2) && (acc_cnt == CNT_W'(PAIR_DIGITS))) begin
                     sh_sec_d = acc_val[SEC_W-1:0];
                     acc_clr  = 1'b1;
                     state_d  = (rx_data_i == CH_DOT) ? ST_FRAC : ST_DAY;
                  end else begin
                     err = 1'b1;
                  end
               end
               ST_FRAC: begin
                  if (is_digit) begin
                     if (acc_cnt >= CNT_W'(MAX_FRAC)) err = 1'b1;
                     else                              acc_stb = 1'b1;
                  end else if (rx_data_i == CH_COMMA) begin
                     acc_clr = 1'b1;
                     state_d = ST_DAY;
                  end else begin
                     err = 1'b1;
                  end
               end
               ST_DAY: begin
                  if (is_digit) begin
                     if (acc_cnt == CNT_W'(DAY_DIGITS)) err = 1'b1;
                     else                               acc_stb = 1'b1;
                  end else if ((rx_data_i == CH_COMMA) && (acc_cnt == CNT_W'(DAY_DIGITS))) begin
                     sh_day_d = acc_val[DAY_W-1:0];
                     acc_clr  = 1'b1;
                     state_d  = ST_MONTH;
                  end else begin
                     err = 1'b1;
                  end
               end
               ST_MONTH: begin
                  if (is_digit) begin
                     if (acc_cnt == CNT_W'(MONTH_DIGITS)) err = 1'b1;
                     else                                 acc_stb = 1'b1;
                  end else if ((rx_data_i == CH_COMMA) && (acc_cnt == CNT_W'(MONTH_DIGITS))) begin
                     sh_mon_d = acc_val[MONTH_W-1:0];
                     acc_clr  = 1'b1;
                     state_d  = ST_YEAR;
                  end else begin
                     err = 1'b1;
                  end
               end
               ST_YEAR: begin
                  if (is_digit) begin
                     if (acc_cnt == CNT_W'(YEAR_DIGITS)) err = 1'b1;
                     else                                acc_stb = 1'b1;
                  end else if ((rx_data_i == CH_COMMA) && (acc_cnt == CNT_W'(YEAR_DIGITS))) begin
                     sh_year_d = acc_val[YEAR_W-1:0];
                     acc_clr   = 1'b1;
                     state_d   = ST_SKIP;
                  end else begin
                     err = 1'b1;
                  end
               end
               ST_SKIP: begin
                  // zone fields are not used; only the '*' matters
                  if (rx_data_i == CH_STAR) begin
`ifdef NMEA_ZDA_CHKSUM_EN
                     state_d = ST_CHK_HI;
`else
                     publish = 1'b1;
                     state_d = ST_IDLE;
`endif
                  end
               end
`ifdef NMEA_ZDA_CHKSUM_EN
               ST_CHK_HI: begin
                  if (is_hex(rx_data_i)) begin
                     chk_hi_d = hex_val(rx_data_i);
                     state_d  = ST_CHK_LO;
                  end else begin
                     err = 1'b1;
                  end
               end
               ST_CHK_LO: begin
                  if (is_hex(rx_data_i) && ({chk_hi_q, hex_val(rx_data_i)} == chk_q)) publish = 1'b1;
                  else                                                                 err = 1'b1;
                  state_d = ST_IDLE;
               end
`endif
               default: state_d = ST_IDLE;
            endcase
         end
      end
      if (err) state_d = ST_IDLE;
   end

   // State, shadow and output registers; outputs move only on a publish
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         hdr_idx_q    <= '0;
         pair_q       <= '0;
         sh_hour_q    <= '0;
         sh_min_q     <= '0;
         sh_sec_q     <= '0;
         sh_day_q     <= '0;
         sh_mon_q     <= '0;
         sh_year_q    <= '0;
         hour_o       <= '0;
         minute_o     <= '0;
         second_o     <= '0;
         day_o        <= '0;
         month_o      <= '0;
         year_o       <= '0;
         time_valid_q <= 1'b0;
         parse_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         hdr_idx_q    <= hdr_idx_d;
         pair_q       <= pair_d;
         sh_hour_q    <= sh_hour_d;
         sh_min_q     <= sh_min_d;
         sh_sec_q     <= sh_sec_d;
         sh_day_q     <= sh_day_d;
         sh_mon_q     <= sh_mon_d;
         sh_year_q    <= sh_year_d;
         time_valid_q <= publish;
         parse_err_q  <= err;
         if (publish) begin
            hour_o   <= sh_hour_q;
            minute_o <= sh_min_q;
            second_o <= sh_sec_q;
            day_o    <= sh_day_q;
            month_o  <= sh_mon_q;
            year_o   <= sh_year_q;
         end
      end
   end

`ifdef NMEA_ZDA_CHKSUM_EN
   // Running XOR and the received high checksum nibble
   always_ff @(posedge clk) begin
      if (rst) begin
         chk_q    <= '0;
         chk_hi_q <= '0;
      end else begin
         chk_q    <= chk_d;
         chk_hi_q <= chk_hi_d;
      end
   end
`endif

   assign time_valid_o = time_valid_q;
   assign parse_err_o  = parse_err_q;
   assign busy_o       = (state_q != ST_IDLE);
   assign state_o      = state_q;

endmodule

// File: tb/tb_nmea_zda_ctrl.sv
// Bench for nmea_zda_ctrl. Sentences are built from field values; the expected
// time_valid/parse_err events come from how each sentence was built (good,
// bad checksum, corrupted field). Honors NMEA_ZDA_CHKSUM_EN for the bad-checksum case.
module tb_nmea_zda_ctrl;
   import nmea_pkg::*;

   localparam int W = 40;                      // {kind[1:0], year, month, day, second, minute, hour}
   localparam logic [1:0] K_VALID = 2'b10;     // {time_valid, parse_err}
   localparam logic [1:0] K_ERR   = 2'b01;

   logic clk = 1'b0;
   logic rst;
   logic [7:0] rx_data;
   logic rx_valid;
   logic [HOUR_W-1:0]  hour;
   logic [MIN_W-1:0]   minute;
   logic [SEC_W-1:0]   second;
   logic [DAY_W-1:0]   day;
   logic [MONTH_W-1:0] month;
   logic [YEAR_W-1:0]  year;
   logic time_valid, parse_err, busy;
   nmea_state_e dbg_state;

   int checks = 0;
   int failures = 0;
   logic [W-1:0]  exp_q[$];
   logic [W-3:0]  last_pub;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   nmea_zda_ctrl #(.MAX_FRAC(6)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data_i    (rx_data),
      .rx_valid_i   (rx_valid),
      .hour_o       (hour),
      .minute_o     (minute),
      .second_o     (second),
      .day_o        (day),
      .month_o      (month),
      .year_o       (year),
      .time_valid_o (time_valid),
      .parse_err_o  (parse_err),
      .busy_o       (busy),
      .state_o      (dbg_state)
   );

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W-3:0] pack_fields(input int h, input int m, input int s,
                                                input int d, input int mo, input int y);
      return {12'(y % 4096), 4'(mo % 16), 5'(d % 32), 6'(s % 64), 6'(m % 64), 5'(h % 32)};
   endfunction

   function automatic logic [W-3:0] dut_fields();
      return {year, month, day, second, minute, hour};
   endfunction

   task automatic expect_valid(input int h, input int m, input int s, input int d, input int mo, input int y);
      exp_q.push_back({K_VALID, pack_fields(h, m, s, d, mo, y)});
   endtask

   task automatic expect_err();
      exp_q.push_back({K_ERR, {(W-2){1'b0}}});
   endtask

   task automatic expect_bad_chk(input int h, input int m, input int s, input int d, input int mo, input int y);
`ifdef NMEA_ZDA_CHKSUM_EN
      expect_err();
`else
      expect_valid(h, m, s, d, mo, y);
`endif
   endtask

   // Scoreboard: every pulse must match the head of the expected queue; between
   // pulses the outputs must hold the last published set
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (rst) begin
         last_pub = '0;
      end else if (time_valid || parse_err) begin
         check_val("pulse_exclusive", {63'd0, time_valid && parse_err}, 64'd0);
         if (exp_q.size() == 0) begin
            check_val("unexpected_pulse", {62'd0, time_valid, parse_err}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check_val("pulse_kind", {62'd0, time_valid, parse_err}, {62'd0, e[W-1:W-2]});
            if (e[W-1:W-2] == K_VALID) begin
               check_val("published_fields", dut_fields(), e[W-3:0]);
               last_pub = e[W-3:0];
            end else begin
               check_val("hold_on_err", dut_fields(), last_pub);
            end
         end
      end else begin
         check_val("hold", dut_fields(), last_pub);
      end
   end

   // ---------------- driver ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom_range(0, 255));
   endtask

   task automatic send_str(input string s, input int min_gap, input int max_gap);
      for (int i = 0; i < s.len(); i++) begin
         send_byte(s[i]);
         idle($urandom_range(min_gap, max_gap));
      end
   endtask

   function automatic string sentence(input string body, input bit good);
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < body.len(); i++) x = x ^ body[i];
      if (!good) x = x + 8'd1;
      return {"$", body, "*", $sformatf("%02X", x), "\r\n"};
   endfunction

   // nfrac < 0 omits the fraction; bad_pos >= 0 puts a letter into that TIME digit
   function automatic string zda_body(input int h, input int m, input int s, input int nfrac,
                                      input int d, input int mo, input int y,
                                      input bit short_year, input int bad_pos);
      string t;
      t = {"GPZDA,", $sformatf("%02d%02d%02d", h, m, s)};
      if (nfrac >= 0) begin
         t = {t, "."};
         for (int k = 0; k < nfrac; k++) t = {t, $sformatf("%0d", $urandom_range(0, 9))};
      end
      t = {t, $sformatf(",%02d,%02d,", d, mo)};
      if (short_year) t = {t, $sformatf("%03d", y % 1000)};
      else            t = {t, $sformatf("%04d", y)};
      t = {t, $sformatf(",%02d,%02d", $urandom_range(0, 13), $urandom_range(0, 59))};
      if (bad_pos >= 0) t.putc(6 + bad_pos, "x");
      return t;
   endfunction

   // ---------------- stimulus ----------------
   string good_s;

   initial begin
      good_s   = "$GPZDA,172809.456,12,07,1996,00,00*57\r\n";
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(3);
      check_val("reset_outputs", dut_fields(), '0);
      check_val("reset_busy", {63'd0, busy}, 64'd0);
      check_val("reset_pulses", {62'd0, time_valid, parse_err}, 64'd0);
      rst = 1'b0;
      idle(2);

      // good sentence, back-to-back bytes
      expect_valid(17, 28, 9, 12, 7, 1996);
      send_str(good_s, 0, 0);
      idle(2);
      check_val("busy_after_sentence", {63'd0, busy}, 64'd0);

      // one idle cycle between bytes
      expect_valid(17, 28, 9, 12, 7, 1996);
      send_str(good_s, 1, 1);

      // wrong checksum
      expect_bad_chk(17, 28, 9, 12, 7, 1996);
      send_str("$GPZDA,172809.456,12,07,1996,00,00*58\r\n", 0, 0);
      idle(2);

      // other sentence type is ignored, then a good ZDA
      send_str("$GPRMC,123519,A,4807.038,N,01131.000,E*6A\r\n", 0, 0);
      expect_valid(17, 28, 9, 12, 7, 1996);
      send_str(good_s, 0, 0);

      // letter in TIME: error pulse right after the 'a'
      expect_err();
      send_str("$GPZDA,17a", 0, 0);
      check_val("err_at_letter", {63'd0, parse_err}, 64'd1);
      send_str("809.456,12,07,1996,00,00*57\r\n", 0, 0);

      // short TIME: error pulse right after the ','
      expect_err();
      send_str("$GPZDA,1728,", 0, 0);
      check_val("err_at_comma", {63'd0, parse_err}, 64'd1);
      send_str("12,07,1996,00,00*57\r\n", 0, 0);

      // busy inside the header, then '$' restarts; partial sentence aborted without error
      send_str("$GP", 0, 0);
      check_val("busy_in_header", {63'd0, busy}, 64'd1);
      send_str("$GPZDA,1728", 0, 0);
      expect_valid(17, 28, 9, 12, 7, 1996);
      send_str(good_s, 0, 0);

      // out-of-range values pass through truncated; no fraction
      expect_valid(39, 75, 59, 31, 12, 2024);
      send_str(sentence("GPZDA,397559,31,12,2024,00,00", 1'b1), 0, 0);

      // maximum fraction length is accepted
      expect_valid(0, 0, 0, 1, 1, 2000);
      send_str(sentence("GPZDA,000000.123456,01,01,2000,00,00", 1'b1), 0, 0);

      // reset mid-sentence clears the published outputs
      send_str("$GPZDA,1728", 0, 0);
      rst = 1'b1;
      idle(1);
      check_val("reset_mid_outputs", dut_fields(), '0);
      check_val("reset_mid_busy", {63'd0, busy}, 64'd0);
      idle(1);
      rst = 1'b0;
      expect_valid(17, 28, 9, 12, 7, 1996);
      send_str(good_s, 0, 0);

      // randomized sentences
      for (int n = 0; n < 60; n++) begin
         int h, m, s, d, mo, y, mode, nfrac;
         h  = $urandom_range(0, 23);
         m  = $urandom_range(0, 59);
         s  = $urandom_range(0, 59);
         d  = $urandom_range(1, 31);
         mo = $urandom_range(1, 12);
         y  = $urandom_range(1000, 9999);
         nfrac = $urandom_range(0, 7) - 1;
         mode  = $urandom_range(0, 5);
         case (mode)
            2: begin
               expect_bad_chk(h, m, s, d, mo, y);
               good_s = sentence(zda_body(h, m, s, nfrac, d, mo, y, 1'b0, -1), 1'b0);
            end
            3: begin
               expect_err();
               good_s = sentence(zda_body(h, m, s, nfrac, d, mo, y, 1'b0, $urandom_range(0, 5)), 1'b1);
            end
            4: begin
               expect_err();
               good_s = sentence(zda_body(h, m, s, nfrac, d, mo, y, 1'b1, -1), 1'b1);
            end
            5: begin
               expect_err();
               good_s = sentence(zda_body(h, m, s, 7, d, mo, y, 1'b0, -1), 1'b1);
            end
            default: begin
               expect_valid(h, m, s, d, mo, y);
               good_s = sentence(zda_body(h, m, s, nfrac, d, mo, y, 1'b0, -1), 1'b1);
            end
         endcase
         send_str(good_s, 0, $urandom_range(0, 2));
      end

      idle(10);
      check_val("all_events_seen", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
